// File: rtl/pipeline_stall_controller.sv
// Central stall sequencer for the 5-stage pipeline.
// Merges per-stage stall requests into the stall vector for the PC and the inter-stage
// latches (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB). It sequences multi-cycle EX
// operations with a countdown FSM, counts stalled cycles and flags stuck stalls.
module pipeline_stall_controller #(
  parameter int EX_COUNT_WIDTH = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WATCHDOG_WIDTH = 16,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      if_stall_request,
  input  logic                      id_stall_request,
  input  logic                      ex_start,
  input  logic [EX_COUNT_WIDTH-1:0] ex_cycles,
  input  logic                      mem_stall_request,
  output logic [5:0]                stall,
  output logic                      ex_busy,
  output logic                      ex_done,
  output logic [PERF_WIDTH-1:0]     stall_cycle_count,
  output logic                      stall_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } ex_state_t;

  localparam logic [WATCHDOG_WIDTH-1:0] TIMEOUT_VALUE = WATCHDOG_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WATCHDOG_WIDTH-1:0] TIMEOUT_LAST  = WATCHDOG_WIDTH'(TIMEOUT_CYCLES - 1);

  ex_state_t                 state;
  logic [EX_COUNT_WIDTH-1:0] countdown;
  logic [EX_COUNT_WIDTH-1:0] ex_load;
  logic                      done_first;
  logic [WATCHDOG_WIDTH-1:0] watchdog;
  logic                      any_stall;

  // A zero cycle count means a single-cycle op, so the loaded countdown is max(n,1)-1.
  always_comb begin
    ex_load = '0;
    if (ex_cycles != '0) begin
      ex_load = ex_cycles - EX_COUNT_WIDTH'(1);
    end
  end

  // Priority merge of stall sources: the deepest stalled stage decides the vector.
  always_comb begin
    stall = 6'b000000;
    if (reset || flush) begin
      stall = 6'b000000;
    end else if (mem_stall_request) begin
      stall = 6'b011111;
    end else if (state == BUSY) begin
      stall = 6'b001111;
    end else if (id_stall_request) begin
      stall = 6'b000111;
    end else if (if_stall_request) begin
      stall = 6'b000011;
    end
  end

  assign any_stall = (stall != 6'b000000);
  assign ex_busy   = !reset && (state == BUSY);
  assign ex_done   = !reset && !flush && (state == DONE) && done_first;

  // EX multi-cycle sequencer; done_first marks the one DONE cycle that reports the result.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state      <= IDLE;
      countdown  <= '0;
      done_first <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_first <= 1'b0;
          if (ex_start && !mem_stall_request) begin
            countdown <= ex_load;
            if (ex_load == '0) begin
              state      <= DONE;
              done_first <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          countdown <= countdown - EX_COUNT_WIDTH'(1);
          if (countdown <= EX_COUNT_WIDTH'(1)) begin
            state      <= DONE;
            done_first <= 1'b1;
          end
        end
        DONE: begin
          done_first <= 1'b0;
          if (!stall[3]) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          countdown  <= '0;
          done_first <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog counts consecutive stalled cycles and latches a sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      watchdog      <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (!any_stall) begin
        watchdog <= '0;
      end else if (watchdog < TIMEOUT_VALUE) begin
        watchdog <= watchdog + WATCHDOG_WIDTH'(1);
      end
      if (any_stall && (watchdog >= TIMEOUT_LAST)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

  // Performance counter of stalled cycles, wrapping naturally at its width.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycle_count <= '0;
    end else if (any_stall) begin
      stall_cycle_count <= stall_cycle_count + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller with hand-computed expected vectors.
// A short timeout and a narrow perf counter make the watchdog trip and counter wrap quickly.
module tb_pipeline_stall_controller;

  localparam int EX_COUNT_WIDTH = 6;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int WATCHDOG_WIDTH = 16;
  localparam int PERF_WIDTH     = 3;

  logic                      clock;
  logic                      reset;
  logic                      flush;
  logic                      if_stall_request;
  logic                      id_stall_request;
  logic                      ex_start;
  logic [EX_COUNT_WIDTH-1:0] ex_cycles;
  logic                      mem_stall_request;
  logic [5:0]                stall;
  logic                      ex_busy;
  logic                      ex_done;
  logic [PERF_WIDTH-1:0]     stall_cycle_count;
  logic                      stall_timeout;

  int checks;
  int errors;
  int expPerf;
  logic expTimeout;

  pipeline_stall_controller #(
    .EX_COUNT_WIDTH(EX_COUNT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WATCHDOG_WIDTH(WATCHDOG_WIDTH),
    .PERF_WIDTH(PERF_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .if_stall_request(if_stall_request),
    .id_stall_request(id_stall_request),
    .ex_start(ex_start),
    .ex_cycles(ex_cycles),
    .mem_stall_request(mem_stall_request),
    .stall(stall),
    .ex_busy(ex_busy),
    .ex_done(ex_done),
    .stall_cycle_count(stall_cycle_count),
    .stall_timeout(stall_timeout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic ifr, input logic idr,
                               input logic exs, input logic [EX_COUNT_WIDTH-1:0] exc,
                               input logic memr);
    flush             = fl;
    if_stall_request  = ifr;
    id_stall_request  = idr;
    ex_start          = exs;
    ex_cycles         = exc;
    mem_stall_request = memr;
  endtask

  task automatic runCycle(input string tag, input logic [5:0] expStall,
                          input logic expBusy, input logic expDone);
    #1;
    checkOutput({tag, ".stall"}, 32'(stall), 32'(expStall));
    checkOutput({tag, ".busy"}, 32'(ex_busy), 32'(expBusy));
    checkOutput({tag, ".done"}, 32'(ex_done), 32'(expDone));
    checkOutput({tag, ".perf"}, 32'(stall_cycle_count), 32'(expPerf % (1 << PERF_WIDTH)));
    checkOutput({tag, ".timeout"}, 32'(stall_timeout), 32'(expTimeout));
    @(posedge clock);
    if (expStall != 6'b000000) expPerf++;
    @(negedge clock);
  endtask

  task automatic doReset(input int cycles);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      #1;
      checkOutput("reset.stall", 32'(stall), 32'd0);
      checkOutput("reset.busy", 32'(ex_busy), 32'd0);
      checkOutput("reset.done", 32'(ex_done), 32'd0);
      @(posedge clock);
      @(negedge clock);
    end
    reset      = 1'b0;
    expPerf    = 0;
    expTimeout = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    checks     = 0;
    errors     = 0;
    expPerf    = 0;
    expTimeout = 1'b0;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    doReset(3);
    runCycle("t1.idle", 6'b000000, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    runCycle("t2.all", 6'b011111, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    runCycle("t2.id", 6'b000111, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    runCycle("t2.if", 6'b000011, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    runCycle("t2.flush", 6'b000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    runCycle("t2.quiet", 6'b000000, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    runCycle("t3.start", 6'b000000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) runCycle("t3.busy", 6'b001111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    runCycle("t3.done", 6'b000000, 1'b0, 1'b1);
    runCycle("t3.idle", 6'b000000, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, EX_COUNT_WIDTH'(n), 1'b0);
      runCycle("t3.single.start", 6'b000000, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      runCycle("t3.single.done", 6'b000000, 1'b0, 1'b1);
      runCycle("t3.single.idle", 6'b000000, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    runCycle("t4.start", 6'b000000, 1'b0, 1'b0);
    runCycle("t4.busy1", 6'b001111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1);
    runCycle("t4.busy2mem", 6'b011111, 1'b1, 1'b0);
    runCycle("t4.busy3mem", 6'b011111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    runCycle("t4.busy4", 6'b001111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    runCycle("t4.done1mem", 6'b011111, 1'b0, 1'b1);
    runCycle("t4.done2mem", 6'b011111, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1);
    runCycle("t4.done3mem", 6'b011111, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0);
    runCycle("t4.leave", 6'b000000, 1'b0, 1'b0);
    runCycle("t4.rearm", 6'b000000, 1'b0, 1'b0);
    runCycle("t4.busyA", 6'b001111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    runCycle("t4.busyB", 6'b001111, 1'b1, 1'b0);
    runCycle("t4.done", 6'b000000, 1'b0, 1'b1);
    runCycle("t4.idle", 6'b000000, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    runCycle("t5.start", 6'b000000, 1'b0, 1'b0);
    runCycle("t5.busy1", 6'b001111, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    runCycle("t5.flush", 6'b000000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    runCycle("t5.after", 6'b000000, 1'b0, 1'b0);
    runCycle("t5.idle", 6'b000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
    runCycle("t5.restart", 6'b000000, 1'b0, 1'b0);
    runCycle("t5.rebusy", 6'b001111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    runCycle("t5.redone", 6'b000000, 1'b0, 1'b1);
    runCycle("t5.reidle", 6'b000000, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    runCycle("t5.rst.start", 6'b000000, 1'b0, 1'b0);
    runCycle("t5.rst.busy", 6'b001111, 1'b1, 1'b0);
    doReset(1);
    runCycle("t5.rst.after", 6'b000000, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      runCycle("t6.hold", 6'b000011, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    expTimeout = 1'b1;
    runCycle("t6.tripped", 6'b000000, 1'b0, 1'b0);
    runCycle("t6.sticky", 6'b000000, 1'b0, 1'b0);
    doReset(2);
    runCycle("t6.cleared", 6'b000000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
